// File: rtl/cpu_ctrl_pkg.sv
// Opcode map, ALU increment code, sequencer state enum and control vector shared by the CPU.
// Optional multiply/divide sequencing is enabled by defining CU_MULDIV_EN.
package cpu_ctrl_pkg;

    localparam logic [4:0] OPC_LD   = 5'd0;
    localparam logic [4:0] OPC_LDI  = 5'd1;
    localparam logic [4:0] OPC_ST   = 5'd2;
    localparam logic [4:0] OPC_ADD  = 5'd3;
    localparam logic [4:0] OPC_SUB  = 5'd4;
    localparam logic [4:0] OPC_AND  = 5'd5;
    localparam logic [4:0] OPC_OR   = 5'd6;
    localparam logic [4:0] OPC_SHR  = 5'd7;
    localparam logic [4:0] OPC_SHRA = 5'd8;
    localparam logic [4:0] OPC_SHL  = 5'd9;
    localparam logic [4:0] OPC_ROR  = 5'd10;
    localparam logic [4:0] OPC_ROL  = 5'd11;
    localparam logic [4:0] OPC_ADDI = 5'd12;
    localparam logic [4:0] OPC_ANDI = 5'd13;
    localparam logic [4:0] OPC_ORI  = 5'd14;
    localparam logic [4:0] OPC_MUL  = 5'd15;
    localparam logic [4:0] OPC_DIV  = 5'd16;
    localparam logic [4:0] OPC_NEG  = 5'd17;
    localparam logic [4:0] OPC_NOT  = 5'd18;
    localparam logic [4:0] OPC_BR   = 5'd19;
    localparam logic [4:0] OPC_JR   = 5'd20;
    localparam logic [4:0] OPC_IN   = 5'd21;
    localparam logic [4:0] OPC_OUT  = 5'd22;
    localparam logic [4:0] OPC_MFHI = 5'd23;
    localparam logic [4:0] OPC_MFLO = 5'd24;
    localparam logic [4:0] OPC_NOP  = 5'd25;
    localparam logic [4:0] OPC_HALT = 5'd26;

    localparam logic [4:0] OP_INC   = 5'd31;

    typedef enum logic [3:0] {
        ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } state_t;

    typedef struct packed {
        logic       pc_out;
        logic       hi_out;
        logic       lo_out;
        logic       zhigh_out;
        logic       zlow_out;
        logic       mdr_out;
        logic       c_out;
        logic       inport_out;
        logic       pc_in;
        logic       ir_in;
        logic       hi_in;
        logic       lo_in;
        logic       y_in;
        logic       z_in;
        logic       mar_in;
        logic       mdr_in;
        logic       con_in;
        logic       outport_in;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic       ba_out;
        logic       read;
        logic       write;
        logic [4:0] alu_op;
    } ctrl_t;

    function automatic logic is_muldiv(input logic [4:0] op);
`ifdef CU_MULDIV_EN
        return (op == OPC_MUL) || (op == OPC_DIV);
`else
        return 1'b0;
`endif
    endfunction

    // Final execute step of each instruction; T2 means no execute phase at all.
    function automatic state_t last_step(input logic [4:0] op);
        if (op == OPC_LD || op == OPC_ST)
            return ST_T7;
        else if (op == OPC_BR || is_muldiv(op))
            return ST_T6;
        else if (op == OPC_LDI || (op >= OPC_ADD && op <= OPC_ORI))
            return ST_T5;
        else if (op == OPC_NEG || op == OPC_NOT)
            return ST_T4;
        else if (op >= OPC_JR && op <= OPC_MFLO)
            return ST_T3;
        else
            return ST_T2;
    endfunction

endpackage

// File: rtl/ctrl_step_decoder.sv
// Combinational decode of (state, opcode, CON_FF) into the datapath control vector.
// Zero latency, no handshake: outputs follow the state register within the cycle.
module ctrl_step_decoder
    import cpu_ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic [4:0] opcode_i,
    input  logic       con_ff_i,
    output ctrl_t      ctrl_o
);

    logic reg_alu, imm_alu, unary, mem_op, muldiv;

    assign reg_alu = (opcode_i >= OPC_ADD) && (opcode_i <= OPC_ROL);
    assign imm_alu = (opcode_i >= OPC_ADDI) && (opcode_i <= OPC_ORI);
    assign unary   = (opcode_i == OPC_NEG) || (opcode_i == OPC_NOT);
    assign mem_op  = (opcode_i == OPC_LD) || (opcode_i == OPC_LDI) || (opcode_i == OPC_ST);
    assign muldiv  = is_muldiv(opcode_i);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_T0: begin
                ctrl_o.pc_out = 1'b1; ctrl_o.mar_in = 1'b1; ctrl_o.z_in = 1'b1;
                ctrl_o.alu_op = OP_INC;
            end
            ST_T1: begin
                ctrl_o.zlow_out = 1'b1; ctrl_o.pc_in = 1'b1;
                ctrl_o.read = 1'b1; ctrl_o.mdr_in = 1'b1;
            end
            ST_T2: begin
                ctrl_o.mdr_out = 1'b1; ctrl_o.ir_in = 1'b1;
            end
            ST_T3: begin
                if (reg_alu || imm_alu) begin
                    ctrl_o.grb = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.y_in = 1'b1;
                end else if (unary) begin
                    ctrl_o.grb = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.z_in = 1'b1;
                    ctrl_o.alu_op = opcode_i;
                end else if (mem_op) begin
                    // Base register reads as zero when Rb is R0 (BAout).
                    ctrl_o.grb = 1'b1; ctrl_o.ba_out = 1'b1; ctrl_o.y_in = 1'b1;
                end else if (muldiv) begin
                    ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.y_in = 1'b1;
                end else begin
                    case (opcode_i)
                        OPC_BR:   begin ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.con_in = 1'b1; end
                        OPC_JR:   begin ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.pc_in = 1'b1; end
                        OPC_IN:   begin ctrl_o.inport_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1; end
                        OPC_OUT:  begin ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.outport_in = 1'b1; end
                        OPC_MFHI: begin ctrl_o.hi_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1; end
                        OPC_MFLO: begin ctrl_o.lo_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1; end
                        default: ;
                    endcase
                end
            end
            ST_T4: begin
                if (reg_alu) begin
                    ctrl_o.grc = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.z_in = 1'b1;
                    ctrl_o.alu_op = opcode_i;
                end else if (imm_alu) begin
                    ctrl_o.c_out = 1'b1; ctrl_o.z_in = 1'b1; ctrl_o.alu_op = opcode_i;
                end else if (unary) begin
                    ctrl_o.zlow_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1;
                end else if (mem_op) begin
                    ctrl_o.c_out = 1'b1; ctrl_o.z_in = 1'b1; ctrl_o.alu_op = OPC_ADD;
                end else if (muldiv) begin
                    ctrl_o.grb = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.z_in = 1'b1;
                    ctrl_o.alu_op = opcode_i;
                end else if (opcode_i == OPC_BR) begin
                    ctrl_o.pc_out = 1'b1; ctrl_o.y_in = 1'b1;
                end
            end
            ST_T5: begin
                if (reg_alu || imm_alu || opcode_i == OPC_LDI) begin
                    ctrl_o.zlow_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1;
                end else if (opcode_i == OPC_LD || opcode_i == OPC_ST) begin
                    ctrl_o.zlow_out = 1'b1; ctrl_o.mar_in = 1'b1;
                end else if (muldiv) begin
                    ctrl_o.zlow_out = 1'b1; ctrl_o.lo_in = 1'b1;
                end else if (opcode_i == OPC_BR) begin
                    ctrl_o.c_out = 1'b1; ctrl_o.z_in = 1'b1; ctrl_o.alu_op = OPC_ADD;
                end
            end
            ST_T6: begin
                if (opcode_i == OPC_LD) begin
                    ctrl_o.read = 1'b1; ctrl_o.mdr_in = 1'b1;
                end else if (opcode_i == OPC_ST) begin
                    ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.mdr_in = 1'b1;
                end else if (muldiv) begin
                    ctrl_o.zhigh_out = 1'b1; ctrl_o.hi_in = 1'b1;
                end else if (opcode_i == OPC_BR) begin
                    // Branch target is always on the bus; only the PC load is conditional.
                    ctrl_o.zlow_out = 1'b1; ctrl_o.pc_in = con_ff_i;
                end
            end
            ST_T7: begin
                if (opcode_i == OPC_LD) begin
                    ctrl_o.mdr_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1;
                end else if (opcode_i == OPC_ST) begin
                    ctrl_o.write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer driving every datapath strobe; Moore outputs, one step per clock.
// No backpressure: the datapath always completes a step in one cycle; clr low forces RST next cycle.
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    output logic        PCout,
    output logic        HIout,
    output logic        LOout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        Cout,
    output logic        InPortOut,
    output logic        PCin,
    output logic        IRin,
    output logic        HIin,
    output logic        LOin,
    output logic        Yin,
    output logic        Zin,
    output logic        MARin,
    output logic        MDRin,
    output logic        CONin,
    output logic        OutportIn,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  OpCode,
    output logic        Run
);

    state_t     state_q, state_d;
    state_t     last;
    logic [4:0] opcode;
    logic       unused_ir;
    ctrl_t      ctrl;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];
    assign last      = last_step(opcode);

    always_ff @(posedge clk) begin
        if (!clr)
            state_q <= ST_RST;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST:  state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1:   state_d = ST_T2;
            ST_T2: begin
                if (opcode == OPC_HALT)
                    state_d = ST_HALT;
                else if (last == ST_T2)
                    state_d = ST_T0;
                else
                    state_d = ST_T3;
            end
            ST_T3:   state_d = (last == ST_T3) ? ST_T0 : ST_T4;
            ST_T4:   state_d = (last == ST_T4) ? ST_T0 : ST_T5;
            ST_T5:   state_d = (last == ST_T5) ? ST_T0 : ST_T6;
            ST_T6:   state_d = (last == ST_T6) ? ST_T0 : ST_T7;
            ST_T7:   state_d = ST_T0;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
    end

    ctrl_step_decoder u_step_decoder (
        .state_i  (state_q),
        .opcode_i (opcode),
        .con_ff_i (CON_FF),
        .ctrl_o   (ctrl)
    );

    always_comb begin
        Run = (state_q != ST_RST) && (state_q != ST_HALT);
    end

    assign PCout     = ctrl.pc_out;
    assign HIout     = ctrl.hi_out;
    assign LOout     = ctrl.lo_out;
    assign Zhighout  = ctrl.zhigh_out;
    assign Zlowout   = ctrl.zlow_out;
    assign MDRout    = ctrl.mdr_out;
    assign Cout      = ctrl.c_out;
    assign InPortOut = ctrl.inport_out;
    assign PCin      = ctrl.pc_in;
    assign IRin      = ctrl.ir_in;
    assign HIin      = ctrl.hi_in;
    assign LOin      = ctrl.lo_in;
    assign Yin       = ctrl.y_in;
    assign Zin       = ctrl.z_in;
    assign MARin     = ctrl.mar_in;
    assign MDRin     = ctrl.mdr_in;
    assign CONin     = ctrl.con_in;
    assign OutportIn = ctrl.outport_in;
    assign Gra       = ctrl.gra;
    assign Grb       = ctrl.grb;
    assign Grc       = ctrl.grc;
    assign Rin       = ctrl.r_in;
    assign Rout      = ctrl.r_out;
    assign BAout     = ctrl.ba_out;
    assign Read      = ctrl.read;
    assign Write     = ctrl.write;
    assign OpCode    = ctrl.alu_op;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed instructions then random opcodes against a step-list model.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] IR = 32'd0;
    logic        CON_FF = 1'b0;
    logic PCout, HIout, LOout, Zhighout, Zlowout, MDRout, Cout, InPortOut;
    logic PCin, IRin, HIin, LOin, Yin, Zin, MARin, MDRin, CONin, OutportIn;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, Run;
    logic [4:0] OpCode;

    int tests = 0;
    int fails = 0;

    control_unit dut (
        .clk(clk), .clr(clr), .IR(IR), .CON_FF(CON_FF),
        .PCout(PCout), .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout),
        .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout), .InPortOut(InPortOut),
        .PCin(PCin), .IRin(IRin), .HIin(HIin), .LOin(LOin), .Yin(Yin), .Zin(Zin),
        .MARin(MARin), .MDRin(MDRin), .CONin(CONin), .OutportIn(OutportIn),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Read(Read), .Write(Write), .OpCode(OpCode), .Run(Run)
    );

    always #5 clk = ~clk;

    // Strobe masks, MSB (PCout) to LSB (Write) in the order of obs below.
    localparam logic [25:0] PCOUT = 26'h1 << 25, HIOUT = 26'h1 << 24, LOOUT = 26'h1 << 23,
        ZHIGHOUT = 26'h1 << 22, ZLOWOUT = 26'h1 << 21, MDROUT = 26'h1 << 20, COUT = 26'h1 << 19,
        INPORTOUT = 26'h1 << 18, PCIN = 26'h1 << 17, IRIN = 26'h1 << 16, HIIN = 26'h1 << 15,
        LOIN = 26'h1 << 14, YIN = 26'h1 << 13, ZIN = 26'h1 << 12, MARIN = 26'h1 << 11,
        MDRIN = 26'h1 << 10, CONIN = 26'h1 << 9, OUTPORTIN = 26'h1 << 8, GRA = 26'h1 << 7,
        GRB = 26'h1 << 6, GRC = 26'h1 << 5, RIN = 26'h1 << 4, ROUT = 26'h1 << 3,
        BAOUT = 26'h1 << 2, READ = 26'h1 << 1, WRITE = 26'h1;

    logic [31:0] obs;
    assign obs = {Run, OpCode, PCout, HIout, LOout, Zhighout, Zlowout, MDRout, Cout, InPortOut,
                  PCin, IRin, HIin, LOin, Yin, Zin, MARin, MDRin, CONin, OutportIn,
                  Gra, Grb, Grc, Rin, Rout, BAout, Read, Write};

    logic [25:0] em[$];
    logic [4:0]  eo[$];

    task automatic push(input logic [25:0] m, input logic [4:0] o);
        em.push_back(m);
        eo.push_back(o);
    endtask

    // Instruction as the list of per-step strobe sets, fetch included.
    task automatic build(input logic [4:0] op, input logic con);
        em.delete();
        eo.delete();
        push(PCOUT | MARIN | ZIN, 5'd31);
        push(ZLOWOUT | PCIN | READ | MDRIN, 5'd0);
        push(MDROUT | IRIN, 5'd0);
        if (op >= 5'd3 && op <= 5'd11) begin
            push(GRB | ROUT | YIN, 5'd0);
            push(GRC | ROUT | ZIN, op);
            push(ZLOWOUT | GRA | RIN, 5'd0);
        end else if (op >= 5'd12 && op <= 5'd14) begin
            push(GRB | ROUT | YIN, 5'd0);
            push(COUT | ZIN, op);
            push(ZLOWOUT | GRA | RIN, 5'd0);
        end else if (op == 5'd17 || op == 5'd18) begin
            push(GRB | ROUT | ZIN, op);
            push(ZLOWOUT | GRA | RIN, 5'd0);
        end else if (op <= 5'd2) begin
            push(GRB | BAOUT | YIN, 5'd0);
            push(COUT | ZIN, 5'd3);
            if (op == 5'd1) begin
                push(ZLOWOUT | GRA | RIN, 5'd0);
            end else begin
                push(ZLOWOUT | MARIN, 5'd0);
                if (op == 5'd0) begin
                    push(READ | MDRIN, 5'd0);
                    push(MDROUT | GRA | RIN, 5'd0);
                end else begin
                    push(GRA | ROUT | MDRIN, 5'd0);
                    push(WRITE, 5'd0);
                end
            end
        end else if (op == 5'd19) begin
            push(GRA | ROUT | CONIN, 5'd0);
            push(PCOUT | YIN, 5'd0);
            push(COUT | ZIN, 5'd3);
            push(ZLOWOUT | (con ? PCIN : 26'd0), 5'd0);
        end else if (op == 5'd20) push(GRA | ROUT | PCIN, 5'd0);
        else if (op == 5'd21) push(INPORTOUT | GRA | RIN, 5'd0);
        else if (op == 5'd22) push(GRA | ROUT | OUTPORTIN, 5'd0);
        else if (op == 5'd23) push(HIOUT | GRA | RIN, 5'd0);
        else if (op == 5'd24) push(LOOUT | GRA | RIN, 5'd0);
`ifdef CU_MULDIV_EN
        else if (op == 5'd15 || op == 5'd16) begin
            push(GRA | ROUT | YIN, 5'd0);
            push(GRB | ROUT | ZIN, op);
            push(ZLOWOUT | LOIN, 5'd0);
            push(ZHIGHOUT | HIIN, 5'd0);
        end
`endif
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s step %0d: got %h want %h", tag, k, obs, expv);
        end
    endtask

    // Precondition: the next falling edge sees T0. abort_at >= 0 pulls clr low after that step.
    task automatic run_instr(input logic [31:0] ir, input logic con, input int abort_at,
                             input string tag);
        logic [4:0] op;
        op = ir[31:27];
        build(op, con);
        for (int k = 0; k < em.size(); k++) begin
            @(negedge clk);
            if (k == 0) begin
                IR = ir;
                CON_FF = con;
            end
            chk(tag, k, {1'b1, eo[k], em[k]});
            if (k == abort_at) begin
                clr = 1'b0;
                @(negedge clk);
                chk({tag, "_clr"}, k + 1, 32'd0);
                clr = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        logic [4:0] op;
        repeat (2) begin
            @(negedge clk);
            chk("reset", 0, 32'd0);
        end
        clr = 1'b1;

        run_instr(32'h18918000, 1'b0, -1, "add");
        run_instr(32'h00900055, 1'b0, -1, "ld");
        run_instr(32'h98000000, 1'b0, -1, "br_nt");
        run_instr(32'h98000000, 1'b1, -1, "br_t");
        run_instr(32'h78000000, 1'b0, -1, "mul");
        run_instr(32'h80000000, 1'b1, -1, "div");
        run_instr(32'h10A00010, 1'b0, -1, "st");
        run_instr(32'hC8000000, 1'b0, -1, "nop");
        run_instr(32'h10A00010, 1'b0, 6, "st_abort");

        run_instr(32'hD0000000, 1'b0, -1, "halt_fetch");
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            CON_FF = i[0];
            chk("halt", i, 32'd0);
        end
        clr = 1'b0;
        @(negedge clk);
        chk("halt_clr", 0, 32'd0);
        clr = 1'b1;
        run_instr(32'h18918000, 1'b0, -1, "add_after_halt");

        for (int n = 0; n < 250; n++) begin
            op = 5'($urandom_range(0, 30));
            if (op >= 5'd26) op = op + 5'd1;
            run_instr({op, 27'($urandom)}, 1'($urandom), -1, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
